// File: rtl/gba_video_pkg.sv
// rtl/gba_video_pkg.sv - shared video types, 720p timing constants and colour helpers
package gba_video_pkg;

    localparam int HDMI_H_ACTIVE = 1280;
    localparam int HDMI_H_TOTAL  = 1650;
    localparam int HDMI_V_ACTIVE = 720;
    localparam int HDMI_V_TOTAL  = 750;

    localparam int OVL_X0 = 256;
    localparam int OVL_X1 = 1024;
    localparam int OVL_Y0 = 24;
    localparam int OVL_Y1 = 696;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb8_t;

    typedef struct packed {
        logic  win;
        logic  dim;
        logic  ovl;
        logic  ovl_in;
        rgb8_t ovl_rgb;
    } pix_flags_t;

    typedef enum logic [1:0] {V_WAIT, V_ACTIVE, V_DONE} v_state_t;
    typedef enum logic {H_IDLE, H_ACTIVE} h_state_t;

    // c_left holds a w-bit channel left-aligned; its MSBs are replicated into the low bits
    function automatic logic [7:0] expand_ch(input logic [7:0] c_left, input int w);
        logic [7:0] r;
        r = c_left;
        if (w > 0) begin
            for (int s = w; s < 8; s += w) begin
                r = r | (c_left >> s);
            end
        end
        return r;
    endfunction

    function automatic rgb8_t bgr5_to_rgb8(input logic [15:0] c);
        rgb8_t p;
        p.r = expand_ch({c[4:0], 3'b000}, 5);
        p.g = expand_ch({c[9:5], 3'b000}, 5);
        p.b = expand_ch({c[14:10], 3'b000}, 5);
        return p;
    endfunction

endpackage

// File: rtl/gba_fb_scaler_if.sv
// rtl/gba_fb_scaler_if.sv - framebuffer BRAM read bus between scaler and memory
interface gba_fb_scaler_if #(
    parameter int ADDR_W = 16,
    parameter int PIX_W  = 18
);
    logic [ADDR_W-1:0] rd_addr;
    logic [PIX_W-1:0]  rd_data;

    modport master (output rd_addr, input rd_data);
    modport slave  (input rd_addr, output rd_data);
endinterface

// File: rtl/gba_bres_step.sv
// rtl/gba_bres_step.sv - Bresenham accumulator; adv flags that the next step moves the source index
module gba_bres_step #(
    parameter int NUM = 9,
    parameter int DEN = 2
) (
    input  logic clk,
    input  logic resetn,
    input  logic clear,
    input  logic step,
    output logic adv
);
    localparam int ACC_W = $clog2(NUM + DEN + 1);

    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] sum;

    assign sum = acc + ACC_W'(DEN);
    assign adv = (sum >= ACC_W'(NUM));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            acc <= '0;
        end else if (clear) begin
            acc <= '0;
        end else if (step) begin
            acc <= adv ? (sum - ACC_W'(NUM)) : sum;
        end
    end
endmodule

// File: rtl/gba_fb_scaler.sv
// rtl/gba_fb_scaler.sv - rational NUM/DEN framebuffer-to-HDMI scaler with overlay and scanline mux
module gba_fb_scaler
    import gba_video_pkg::*;
#(
    parameter int          SRC_W      = 240,
    parameter int          SRC_H      = 160,
    parameter int          SCALE_NUM  = 9,
    parameter int          SCALE_DEN  = 2,
    parameter int          DST_X0     = 100,
    parameter int          DST_Y0     = 0,
    parameter int          CH_W       = 6,
    parameter int          RD_LATENCY = 1,
    parameter int          ADDR_W     = 16,
    parameter logic [23:0] BORDER_RGB = 24'h303030
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic [10:0]            cx,
    input  logic [9:0]             cy,
    input  logic                   scanline_en,
    input  logic                   overlay,
    input  logic [15:0]            overlay_color,
    gba_fb_scaler_if.master        fb,
    output logic [23:0]            rgb,
    output logic                   active,
    output logic                   frame_start
);
    localparam int DST_W  = SRC_W * SCALE_NUM / SCALE_DEN;
    localparam int DST_H  = SRC_H * SCALE_NUM / SCALE_DEN;
    localparam int FB_MAX = SRC_W * SRC_H - 1;
    localparam int HC_W   = $clog2(DST_W + 1);
    localparam int VC_W   = $clog2(DST_H + 1);
    localparam int PIX_W  = 3 * CH_W;

    generate
        if (SCALE_NUM < SCALE_DEN || (SRC_W * SCALE_NUM) % SCALE_DEN != 0
            || (SRC_H * SCALE_NUM) % SCALE_DEN != 0) begin : g_bad_scale
            $error("gba_fb_scaler: scale must be >= 1 and give integer destination size");
        end
        if (RD_LATENCY < 1 || RD_LATENCY > 3) begin : g_bad_latency
            $error("gba_fb_scaler: RD_LATENCY must be 1..3");
        end
    endgenerate

    v_state_t          v_state, v_next;
    h_state_t          h_state, h_next;
    logic [HC_W-1:0]   hcnt;
    logic [VC_W-1:0]   vcnt;
    logic [ADDR_W-1:0] rd_addr_q, line_base;
    logic [ADDR_W:0]   addr_inc, base_inc;
    logic [ADDR_W-1:0] addr_next, base_next;
    logic              start_cond, frame_go, h_go, h_step, h_end, in_win;
    logic              h_adv, v_adv, ovl_win;
    pix_flags_t        flags_d, fo;
    pix_flags_t        flags_q [RD_LATENCY+1];
    rgb8_t             pix, pix_dim;

    gba_bres_step #(.NUM(SCALE_NUM), .DEN(SCALE_DEN)) u_hstep (
        .clk    (clk),
        .resetn (resetn),
        .clear  (h_go),
        .step   (h_step),
        .adv    (h_adv)
    );

    gba_bres_step #(.NUM(SCALE_NUM), .DEN(SCALE_DEN)) u_vstep (
        .clk    (clk),
        .resetn (resetn),
        .clear  (frame_go),
        .step   (h_end),
        .adv    (v_adv)
    );

    assign start_cond = (cx == '0) && (cy == 10'(DST_Y0));
    assign fb.rd_addr = rd_addr_q;

    // Both increments saturate at the last framebuffer word
    assign addr_inc  = {1'b0, rd_addr_q} + (ADDR_W+1)'(1);
    assign base_inc  = {1'b0, line_base} + (ADDR_W+1)'(SRC_W);
    assign addr_next = (addr_inc > (ADDR_W+1)'(FB_MAX)) ? ADDR_W'(FB_MAX) : addr_inc[ADDR_W-1:0];
    assign base_next = (base_inc > (ADDR_W+1)'(FB_MAX)) ? ADDR_W'(FB_MAX) : base_inc[ADDR_W-1:0];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            v_state <= V_WAIT;
            h_state <= H_IDLE;
        end else begin
            v_state <= v_next;
            h_state <= h_next;
        end
    end

    // hcnt is the dest index whose address is on rd_addr; cx at hcnt==DST_W-1 is already past the window
    always_comb begin
        v_next   = v_state;
        h_next   = h_state;
        frame_go = 1'b0;
        h_go     = 1'b0;
        h_step   = 1'b0;
        h_end    = 1'b0;
        in_win   = 1'b0;
        case (v_state)
            V_WAIT: begin
                if (start_cond) begin
                    frame_go = 1'b1;
                    v_next   = V_ACTIVE;
                end
            end
            V_ACTIVE: begin
                if (h_state == H_IDLE) begin
                    if (cx == 11'(DST_X0)) begin
                        h_go   = 1'b1;
                        in_win = 1'b1;
                        h_next = H_ACTIVE;
                    end
                end else if (hcnt == HC_W'(DST_W - 1)) begin
                    h_end  = 1'b1;
                    h_next = H_IDLE;
                    if (vcnt == VC_W'(DST_H - 1)) begin
                        v_next = V_DONE;
                    end
                end else begin
                    h_step = 1'b1;
                    in_win = 1'b1;
                end
            end
            V_DONE: begin
                if (start_cond) begin
                    frame_go = 1'b1;
                    v_next   = V_ACTIVE;
                end else if (cy == '0) begin
                    v_next = V_WAIT;
                end
            end
            default: v_next = V_WAIT;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rd_addr_q   <= '0;
            line_base   <= '0;
            hcnt        <= '0;
            vcnt        <= '0;
            frame_start <= 1'b0;
        end else begin
            frame_start <= frame_go;
            if (frame_go) begin
                line_base <= '0;
                vcnt      <= '0;
            end
            if (h_go) begin
                rd_addr_q <= line_base;
                hcnt      <= '0;
            end else if (h_step) begin
                hcnt <= hcnt + HC_W'(1);
                if (h_adv) begin
                    rd_addr_q <= addr_next;
                end
            end
            if (h_end) begin
                vcnt <= vcnt + VC_W'(1);
                if (v_adv) begin
                    line_base <= base_next;
                end
            end
        end
    end

    assign ovl_win = (cx >= 11'(OVL_X0)) && (cx < 11'(OVL_X1))
                  && (cy >= 10'(OVL_Y0)) && (cy < 10'(OVL_Y1));

    always_comb begin
        flags_d.win     = in_win;
        flags_d.dim     = scanline_en & v_adv;
        flags_d.ovl     = overlay;
        flags_d.ovl_in  = ovl_win;
        flags_d.ovl_rgb = bgr5_to_rgb8(overlay_color);
    end

    assign fo = flags_q[RD_LATENCY];

    always_comb begin
        pix.r     = expand_ch(8'(fb.rd_data[PIX_W-1 -: CH_W]) << (8 - CH_W), CH_W);
        pix.g     = expand_ch(8'(fb.rd_data[2*CH_W-1 -: CH_W]) << (8 - CH_W), CH_W);
        pix.b     = expand_ch(8'(fb.rd_data[CH_W-1 -: CH_W]) << (8 - CH_W), CH_W);
        pix_dim.r = {1'b0, pix.r[7:1]};
        pix_dim.g = {1'b0, pix.g[7:1]};
        pix_dim.b = {1'b0, pix.b[7:1]};
    end

    // flags_q[RD_LATENCY] lines up with the rd_data returned for the same raster position
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i <= RD_LATENCY; i++) begin
                flags_q[i] <= '0;
            end
            rgb    <= BORDER_RGB;
            active <= 1'b0;
        end else begin
            flags_q[0] <= flags_d;
            for (int i = 1; i <= RD_LATENCY; i++) begin
                flags_q[i] <= flags_q[i-1];
            end
            if (fo.ovl) begin
                rgb    <= fo.ovl_in ? fo.ovl_rgb : BORDER_RGB;
                active <= 1'b0;
            end else if (fo.win) begin
                rgb    <= fo.dim ? pix_dim : pix;
                active <= 1'b1;
            end else begin
                rgb    <= BORDER_RGB;
                active <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_gba_fb_scaler.sv
// tb/tb_gba_fb_scaler.sv - directed self-checking bench for gba_fb_scaler
module tb_gba_fb_scaler;

    logic        clk = 1'b0;
    logic        resetn;
    logic [10:0] cx;
    logic [9:0]  cy;
    logic        scanline_en;
    logic        overlay;
    logic [15:0] overlay_color;
    logic        fb_const;

    logic [23:0] rgb_a, rgb_b, rgb_c;
    logic        act_a, act_b, act_c;
    logic        fs_a, fs_b, fs_c;
    logic [17:0] c_stage;

    int n_chk  = 0;
    int n_fail = 0;
    int fsn_a  = 0;
    int fsn_c  = 0;
    int fs0;

    int          exp_h  [11] = '{0, 0, 0, 0, 0, 1, 1, 1, 1, 2, 2};
    int          exp_lb [10] = '{0, 0, 0, 0, 0, 240, 240, 240, 240, 480};
    logic [23:0] exp_sc [5]  = '{24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF, 24'h7F7F7F};

    always #5 clk = ~clk;

    gba_fb_scaler_if #(.ADDR_W(16), .PIX_W(18)) fb_a ();
    gba_fb_scaler_if #(.ADDR_W(16), .PIX_W(18)) fb_b ();
    gba_fb_scaler_if #(.ADDR_W(16), .PIX_W(18)) fb_c ();

    gba_fb_scaler u_a (
        .clk(clk), .resetn(resetn), .cx(cx), .cy(cy), .scanline_en(scanline_en),
        .overlay(overlay), .overlay_color(overlay_color), .fb(fb_a),
        .rgb(rgb_a), .active(act_a), .frame_start(fs_a)
    );

    gba_fb_scaler #(.SCALE_NUM(4), .SCALE_DEN(1), .DST_X0(160), .DST_Y0(40)) u_b (
        .clk(clk), .resetn(resetn), .cx(cx), .cy(cy), .scanline_en(scanline_en),
        .overlay(overlay), .overlay_color(overlay_color), .fb(fb_b),
        .rgb(rgb_b), .active(act_b), .frame_start(fs_b)
    );

    gba_fb_scaler #(.SRC_W(8), .SRC_H(6), .RD_LATENCY(2)) u_c (
        .clk(clk), .resetn(resetn), .cx(cx), .cy(cy), .scanline_en(scanline_en),
        .overlay(overlay), .overlay_color(overlay_color), .fb(fb_c),
        .rgb(rgb_c), .active(act_c), .frame_start(fs_c)
    );

    function automatic logic [17:0] mem_rd(input logic [15:0] a);
        return fb_const ? 18'h3FFFF : {2'b00, a};
    endfunction

    always @(posedge clk) begin
        fb_a.rd_data <= mem_rd(fb_a.rd_addr);
        fb_b.rd_data <= mem_rd(fb_b.rd_addr);
        c_stage      <= mem_rd(fb_c.rd_addr);
        fb_c.rd_data <= c_stage;
    end

    always @(negedge clk) begin
        if (fs_a) fsn_a++;
        if (fs_c) fsn_c++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic pix(input int x, input int y);
        cx = 11'(x);
        cy = 10'(y);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        cx     = '0;
        cy     = 10'd500;
        repeat (3) @(posedge clk);
        #1;
        resetn = 1'b1;
    endtask

    task automatic probe(input int ph, input int x, input int y);
        case (ph)
            2: begin
                if (y == 0 && x == 1) check("fs_width", fs_a, 0);
                if (y == 0 && x >= 100 && x <= 110) check("h_step", fb_a.rd_addr, exp_h[x-100]);
                if (y == 0 && x == 101) begin
                    check("pre_win_rgb", rgb_a, 24'h303030);
                    check("pre_win_act", act_a, 0);
                end
                if (y == 0 && x == 102) begin
                    check("first_rgb", rgb_a, 24'h000000);
                    check("first_act", act_a, 1);
                end
                if (y == 0 && x == 107) check("rgb_lat3", rgb_a, 24'h000004);
                if (y == 0 && x == 1179) check("h_last", fb_a.rd_addr, 239);
                if (y == 0 && x == 1181) check("last_rgb", rgb_a, 24'h000CBE);
                if (y == 0 && x == 1182) check("post_win_act", act_a, 0);
                if (x == 100) check("line_base", fb_a.rd_addr, exp_lb[y]);
            end
            3: if (x == 150) check("scanline", rgb_a, exp_sc[y]);
            5: begin
                if (y == 39 && x == 202) begin
                    check("b_pre_rgb", rgb_b, 24'h303030);
                    check("b_pre_act", act_b, 0);
                end
                if (y == 40 && x == 0) check("b_fs", fs_b, 1);
                if (y == 40 && x >= 160 && x <= 164) check("b_h_step", fb_b.rd_addr, (x == 164) ? 1 : 0);
                if (y == 40 && x == 162) check("b_first_rgb", rgb_b, 24'h000000);
                if (y == 40 && x == 166) check("b_rgb", rgb_b, 24'h000004);
            end
            6: begin
                if (y == 0 && x == 107) check("c_lat4_a", rgb_c, 24'h000000);
                if (y == 0 && x == 108) check("c_lat4_b", rgb_c, 24'h000004);
                if (y == 26 && x == 100) check("c_last_base", fb_c.rd_addr, 40);
                if (y == 26 && x == 135) check("c_last_addr", fb_c.rd_addr, 47);
                if (y == 26 && x == 136) check("c_clamp_hold", fb_c.rd_addr, 47);
                if (y == 26 && x == 138) check("c_last_rgb", rgb_c, 24'h0000BE);
                if (y == 26 && x == 139) check("c_post_rgb", rgb_c, 24'h303030);
                if (y == 27 && x == 110) check("c_done_act", act_c, 0);
            end
            7: begin
                if (y == 300 && x == 130) check("mid_act", act_a, 1);
                if (y == 301 && x == 200) begin
                    check("post_rst_rgb", rgb_a, 24'h303030);
                    check("post_rst_act", act_a, 0);
                end
                if (y == 0 && x == 102) check("restart_act", act_a, 1);
            end
            default: ;
        endcase
    endtask

    task automatic sweep(input int ph, input int y, input int x0, input int x1);
        for (int x = x0; x <= x1; x++) begin
            pix(x, y);
            probe(ph, x, y);
        end
    endtask

    initial begin
        resetn        = 1'b0;
        cx            = '0;
        cy            = 10'd500;
        scanline_en   = 1'b0;
        overlay       = 1'b0;
        overlay_color = '0;
        fb_const      = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_addr", fb_a.rd_addr, 0);
        check("rst_rgb", rgb_a, 24'h303030);
        check("rst_act", act_a, 0);
        check("rst_fs", fs_a, 0);
        resetn = 1'b1;

        pix(0, 0);
        check("fs_pulse", fs_a, 1);
        sweep(2, 0, 1, 1185);
        for (int y = 1; y <= 9; y++) sweep(2, y, 0, 1185);
        check("fs_once", fsn_a, 1);

        do_reset();
        fb_const    = 1'b1;
        scanline_en = 1'b1;
        pix(0, 0);
        sweep(3, 0, 1, 1185);
        for (int y = 1; y <= 4; y++) sweep(3, y, 0, 1185);
        fb_const    = 1'b0;
        scanline_en = 1'b0;

        overlay       = 1'b1;
        overlay_color = 16'h001F;
        pix(300, 100);
        overlay_color = 16'h4010;
        pix(500, 200);
        pix(50, 100);
        check("ovl_rgb_red", rgb_a, 24'hFF0000);
        check("ovl_act", act_a, 0);
        pix(50, 100);
        check("ovl_rgb_mix", rgb_a, 24'h840084);
        pix(50, 100);
        check("ovl_border", rgb_a, 24'h303030);
        overlay = 1'b0;

        do_reset();
        sweep(5, 39, 0, 1200);
        sweep(5, 40, 0, 1200);

        do_reset();
        fs0 = fsn_c;
        pix(0, 0);
        sweep(6, 0, 1, 140);
        for (int y = 1; y <= 27; y++) sweep(6, y, 0, 140);
        pix(0, 0);
        check("c_fs_restart", fs_c, 1);
        pix(1, 0);
        check("c_fs_count", fsn_c - fs0, 2);

        do_reset();
        pix(0, 0);
        sweep(7, 0, 1, 1185);
        sweep(7, 300, 0, 150);
        resetn = 1'b0;
        #1;
        check("async_rgb", rgb_a, 24'h303030);
        check("async_act", act_a, 0);
        check("async_addr", fb_a.rd_addr, 0);
        @(posedge clk);
        #1;
        resetn = 1'b1;
        sweep(7, 300, 151, 1185);
        sweep(7, 301, 0, 1185);
        pix(0, 0);
        check("restart_fs", fs_a, 1);
        sweep(7, 0, 1, 110);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/gba_fb_scaler.md
Name: gba_fb_scaler

Overview:
- Generalised framebuffer-to-HDMI scaler, clocked on the pixel clock.
- Takes HDMI raster coordinates, generates read addresses into a SRC_W x SRC_H framebuffer BRAM, and scales by an arbitrary rational factor NUM/DEN using Bresenham stepping on both axes.
- Expands source pixels to RGB8 and muxes border, overlay and optional scanline dimming.
- Replaces the fixed 4.5x address logic; the BRAM itself stays outside the block.

Parameters:
- SRC_W, 240, source width in pixels.
- SRC_H, 160, source height in lines.
- SCALE_NUM, 9, scale numerator; dest size = src size * NUM/DEN.
- SCALE_DEN, 2, scale denominator; must satisfy SCALE_NUM >= SCALE_DEN.
- DST_X0, 100, first active dest column.
- DST_Y0, 0, first active dest line.
- CH_W, 6, bits per source colour channel; pixel width = 3*CH_W, R in MSBs.
- RD_LATENCY, 1, BRAM read latency in clocks (1..3).
- ADDR_W, 16, framebuffer address width.
- BORDER_RGB, 24'h303030, colour outside the active window.

Ports:
- clk  in  1  pixel clock.
- resetn  in  1  asynchronous active-low reset.
- cx  in  11  HDMI raster column.
- cy  in  10  HDMI raster line.
- scanline_en  in  1  enable dimming of the last dest line of each source row.
- overlay  in  1  overlay mode select.
- overlay_color  in  16  BGR5 overlay pixel, aligned with the current cx/cy.
- rd_addr  out  ADDR_W  framebuffer read address.
- rd_data  in  3*CH_W  framebuffer read data, RD_LATENCY clocks after rd_addr.
- rgb  out  24  output pixel.
- active  out  1  rgb is a framebuffer pixel (not border or overlay).
- frame_start  out  1  one-clock pulse at cx==0, cy==DST_Y0.

Behaviour:
- Derived constants: DST_W = SRC_W*NUM/DEN, DST_H = SRC_H*NUM/DEN.
  - Elaboration error if either division is inexact or NUM < DEN.
  - Defaults give 1080x720.
- Reset (async assert, sync release): rd_addr=0, rgb=BORDER_RGB, active=0, frame_start=0. All accumulators and state cleared. Vertical FSM enters V_WAIT.
- Vertical FSM:
  - V_WAIT -> V_ACTIVE when cx==0 && cy==DST_Y0. On that transition: line_base=0, vacc=0, src_y=0; frame_start pulses.
  - V_ACTIVE -> V_DONE after DST_H dest lines.
  - V_DONE -> V_WAIT when cy==0.
  - Reset mid-frame: no output until the next frame start; border only.
- Horizontal FSM (only in V_ACTIVE):
  - H_IDLE -> H_ACTIVE when cx==DST_X0. hacc=0, rd_addr=line_base.
  - H_ACTIVE -> H_IDLE after DST_W pixels.
- Horizontal stepping, per active dest pixel:
  - hacc += DEN; if hacc+DEN >= NUM then hacc += DEN-NUM and rd_addr increments.
  - Source column k = floor(k_dest*DEN/NUM).
  - Defaults give run lengths 5,4,5,4,... per source pixel.
- Vertical stepping: at the H_ACTIVE->H_IDLE edge, vacc steps the same way. On a row advance, line_base += SRC_W; otherwise line_base is held, so the line repeats.
- Clamp: rd_addr never exceeds SRC_W*SRC_H-1. The last dest pixel maps to source (SRC_W-1, SRC_H-1).
- Pipeline latency:
  - (cx,cy) sampled in cycle t.
  - rd_addr is valid in t+1.
  - rd_data is expected in t+1+RD_LATENCY.
  - rgb/active are valid in t+2+RD_LATENCY (default 3).
  - Control flags (window, overlay, dim) are delayed by a matching shift register.
- Colour expansion: each CH_W-bit channel is left-aligned to 8 bits, with MSBs replicated into the low bits. For CH_W=6: 6'h3F -> 8'hFF, 6'h20 -> 8'h82.
- Overlay:
  - Priority: overlay > framebuffer > border.
  - Overlay window: cx in [256,1024), cy in [24,696).
  - BGR5 -> RGB8 with MSB replication. Inside the window, rgb is the overlay colour.
  - Outside the overlay window while overlay=1, rgb=BORDER_RGB.
  - active=0 whenever overlay=1.
- Scanline: when scanline_en=1 and the current dest line is the last repeat of its source row (the next vertical step advances), every channel is halved (>>1). Border and overlay pixels are never dimmed.
- scanline_en and overlay are sampled per pixel; a mid-line change takes effect with the same pipeline latency.

Decomposition:
- Package gba_video_pkg:
  - HDMI 720p timing constants.
  - rgb8_t typedef.
  - Functions expand_ch(CH_W->8) and bgr5_to_rgb8.
- One sub-module, gba_bres_step: accumulator + step flag, parametrised by NUM/DEN, instantiated once per axis.

Test Plan:
- Defaults, cy=0, sweep cx 100..110 -> rd_addr 0,0,0,0,0,1,1,1,1,2,2; cx=1179 gives rd_addr 239; rgb follows 3 clocks after cx.
- Defaults, full frame -> dest lines 0-4 use line_base 0, lines 5-8 use 240; line 719 reads 38160..38399; frame_start pulses once per frame.
- NUM=4, DEN=1, DST_X0=160, DST_Y0=40 -> cx 160..163 read addr 0, cx 164 reads addr 1; cy 39 gives border 24'h303030.
- rd_data=18'h3FFFF inside window, scanline_en=1, defaults -> lines 0-3 rgb=FFFFFF, line 4 rgb=7F7F7F.
- overlay=1, overlay_color=16'h001F at cx=300, cy=100 -> rgb=FF0000, active=0; at cx=50 -> rgb=303030.
- Deassert resetn at cy=300 mid-frame -> outputs at reset values immediately; border until the next cy==DST_Y0 frame start; RD_LATENCY=2 run shows latency 4.
